// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default operand width.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder built from two half adders; the only arithmetic in the serial adder.
module half_adder_bit (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module full_adder_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    logic s_ab;
    logic c_ab;
    logic c_sc;

    half_adder_bit u_ha_ab (
        .a_i (a_i),
        .b_i (b_i),
        .s_o (s_ab),
        .c_o (c_ab)
    );

    half_adder_bit u_ha_sc (
        .a_i (s_ab),
        .b_i (c_i),
        .s_o (s_o),
        .c_o (c_sc)
    );

    assign c_o = c_ab | c_sc;
endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first serial adder: one bit per cycle through a single full adder, WIDTH+1 cycles start to done.
//  state | meaning
//  IDLE  | ready=1, waiting for start; operands captured on the accepting edge
//  SHIFT | busy=1, one sum bit produced per cycle, WIDTH cycles
//  DONE  | done=1 for one cycle, sum/cout final; always returns to IDLE
module bit_serial_adder
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic             ready_q, busy_q, done_q;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fa_s;
    logic             fa_c;

    full_adder_bit u_fa (
        .a_i (a_q[0]),
        .b_i (b_q[0]),
        .c_i (c_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    a_d     = a;
                    b_d     = b;
                    c_d     = cin;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                sum_d = {fa_s, sum_q[WIDTH-1:1]};
                c_d   = fa_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status flags are decoded from the next state so they are registered yet track the FSM exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == IDLE);
            busy_q  <= (state_d == SHIFT);
            done_q  <= (state_d == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
            c_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            sum_q <= sum_d;
            c_q   <= c_d;
            cnt_q <= cnt_d;
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign cout  = c_q;

endmodule
